iiitb_elc_call_sched: RTL and testbench

- Hall/car call scheduler that drives the request side of the iiitb_elc elevator controller.
- Latches floor button presses into a pending set and picks the next target floor with SCAN (continue in current travel direction, else reverse).
- Presents the target as a one-hot request_floor, holds it until the controller reports complete, then retires the call.
- Sits between the button panel and iiitb_elc; consumes the controller's out_current_floor/complete/alerts.

---
 rtl/iiitb_elc_call_sched.sv | 189 ++++++++++++++++++
 tb/tb_iiitb_elc_call_sched.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iiitb_elc_call_sched.sv
// Hall/car call scheduler for the iiitb_elc elevator controller.
// Latches button presses, picks the next target with SCAN ordering, and holds a
// one-hot request until the controller reports complete.
// Optional home-return request is enabled by defining ELC_HOME_RETURN_EN.
module iiitb_elc_call_sched #(
  parameter int unsigned TIMEOUT_CYCLES   = 64,
  parameter int unsigned DWELL_CYCLES     = 2,
  parameter int unsigned HOME_IDLE_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] call_btn,
  input  logic [7:0] out_current_floor,
  input  logic       complete,
  input  logic       door_alert,
  input  logic       weight_alert,
  output logic [7:0] request_floor,
  output logic       req_valid,
  output logic [7:0] pending,
  output logic       scan_up,
  output logic       stall_alert,
  output logic       floor_err
);

  typedef enum logic [1:0] {StIdle, StWait, StStall, StDwell} state_e;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] DwellLast   = 8'(DWELL_CYCLES - 1);
`ifdef ELC_HOME_RETURN_EN
  localparam logic [7:0] HomeLast    = 8'(HOME_IDLE_CYCLES - 1);
`endif

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [7:0] req_q, req_d;
  logic [7:0] pending_q, pending_d;
  logic       scan_up_q, scan_up_d;
  logic       stall_q, stall_d;
  logic       floor_err_q, floor_err_d;
`ifdef ELC_HOME_RETURN_EN
  logic [7:0] idle_q, idle_d;
`endif

  logic [7:0] clr;
  logic [7:0] cand, above, below, c_up, c_dn, lo_up, hi_dn, sel;
  logic       sel_dir;

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      req_q       <= '0;
      pending_q   <= '0;
      scan_up_q   <= 1'b1;
      stall_q     <= 1'b0;
      floor_err_q <= 1'b0;
`ifdef ELC_HOME_RETURN_EN
      idle_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      req_q       <= req_d;
      pending_q   <= pending_d;
      scan_up_q   <= scan_up_d;
      stall_q     <= stall_d;
      floor_err_q <= floor_err_d;
`ifdef ELC_HOME_RETURN_EN
      idle_q      <= idle_d;
`endif
    end
  end

  // SCAN selection: nearest call ahead in the travel direction, else reverse.
  always_comb begin
    above = '0;
    below = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        if (out_current_floor[j] && (j < i)) above[i] = 1'b1;
        if (out_current_floor[j] && (j > i)) below[i] = 1'b1;
      end
    end
    cand  = pending_q & ~out_current_floor;
    c_up  = cand & above;
    c_dn  = cand & below;
    lo_up = '0;
    hi_dn = '0;
    for (int i = 7; i >= 0; i--) begin
      if (c_up[i]) lo_up = 8'b1 << i;
    end
    for (int i = 0; i < 8; i++) begin
      if (c_dn[i]) hi_dn = 8'b1 << i;
    end
    if (scan_up_q) begin
      sel     = (lo_up != '0) ? lo_up : hi_dn;
      sel_dir = (lo_up != '0);
    end else begin
      sel     = (hi_dn != '0) ? hi_dn : lo_up;
      sel_dir = (hi_dn == '0);
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    req_d     = req_q;
    scan_up_d = scan_up_q;
    stall_d   = stall_q;
    clr       = '0;
`ifdef ELC_HOME_RETURN_EN
    idle_d    = '0;
`endif
    unique case (state_q)
      StIdle: begin
        // Calls at the floor we are standing on are served implicitly.
        clr = out_current_floor;
        if ((cand != '0) && !floor_err_q && (sel != '0)) begin
          req_d     = sel;
          scan_up_d = sel_dir;
          timer_d   = '0;
          state_d   = StWait;
        end
`ifdef ELC_HOME_RETURN_EN
        else if ((pending_q == '0) && (call_btn == '0) && (out_current_floor != 8'h01) &&
                 !floor_err_q) begin
          if (idle_q == HomeLast) begin
            req_d   = 8'h01;
            timer_d = '0;
            state_d = StWait;
          end else begin
            idle_d = idle_q + 8'd1;
          end
        end
`endif
      end
      StWait: begin
        if (complete) begin
          clr     = req_q;
          req_d   = '0;
          timer_d = '0;
          state_d = StDwell;
        end else if (!door_alert && !weight_alert) begin
          if (timer_q == TimeoutLast) begin
            stall_d = 1'b1;
            state_d = StStall;
          end else begin
            timer_d = timer_q + 8'd1;
          end
        end
      end
      StStall: begin
        if (complete) begin
          clr     = req_q;
          req_d   = '0;
          stall_d = 1'b0;
          timer_d = '0;
          state_d = StDwell;
        end
      end
      StDwell: begin
        if (timer_q == DwellLast) begin
          timer_d = '0;
          state_d = StIdle;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    // Clear beats a same-cycle press of the same floor.
    pending_d   = (pending_q | call_btn) & ~clr;
    floor_err_d = (out_current_floor == '0) ||
                  ((out_current_floor & (out_current_floor - 8'd1)) != '0);
  end

  // Outputs come straight from registers.
  always_comb begin
    request_floor = req_q;
    req_valid     = (req_q != '0);
    pending       = pending_q;
    scan_up       = scan_up_q;
    stall_alert   = stall_q;
    floor_err     = floor_err_q;
  end

endmodule

// File: tb/tb_iiitb_elc_call_sched.sv
// Self-checking bench for iiitb_elc_call_sched: floor-level behavioural model,
// per-cycle comparison on the falling edge, plus hand-computed spot checks.
module tb_iiitb_elc_call_sched;

  localparam int unsigned TO   = 64;
  localparam int unsigned DW   = 2;
  localparam int unsigned HOME = 32;

  localparam int PhIdle  = 0;
  localparam int PhWait  = 1;
  localparam int PhStall = 2;
  localparam int PhDwell = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] call_btn = 8'h00;
  logic [7:0] out_current_floor = 8'h80;
  logic       complete = 1'b0;
  logic       door_alert = 1'b0;
  logic       weight_alert = 1'b0;
  logic [7:0] request_floor;
  logic       req_valid;
  logic [7:0] pending;
  logic       scan_up;
  logic       stall_alert;
  logic       floor_err;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  iiitb_elc_call_sched #(
    .TIMEOUT_CYCLES  (TO),
    .DWELL_CYCLES    (DW),
    .HOME_IDLE_CYCLES(HOME)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .call_btn         (call_btn),
    .out_current_floor(out_current_floor),
    .complete         (complete),
    .door_alert       (door_alert),
    .weight_alert     (weight_alert),
    .request_floor    (request_floor),
    .req_valid        (req_valid),
    .pending          (pending),
    .scan_up          (scan_up),
    .stall_alert      (stall_alert),
    .floor_err        (floor_err)
  );

  always #5 clk = ~clk;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model state: target floor number (-1 = none) and a phase tag.
  logic [7:0] m_pend;
  int         m_tgt;
  bit         m_up;
  bit         m_stall;
  bit         m_ferr;
  int         m_phase;
  int         m_free;
  int         m_dwell;
  int         m_home;

  function automatic logic [7:0] tgt_mask(input int f);
    return (f < 0) ? 8'h00 : 8'(1 << f);
  endfunction

  always @(posedge clk) begin
    logic [7:0] clr;
    int         cur_idx;
    int         pick;
    clr = 8'h00;
    if (reset) begin
      m_pend = 8'h00; m_tgt = -1; m_up = 1'b1; m_stall = 1'b0; m_ferr = 1'b0;
      m_phase = PhIdle; m_free = 0; m_dwell = 0; m_home = 0;
    end else begin
      cur_idx = -1;
      for (int i = 0; i < 8; i++) if (out_current_floor[i]) cur_idx = i;
      case (m_phase)
        PhIdle: begin
          clr  = out_current_floor;
          pick = -1;
          if (!m_ferr) begin
            if (m_up) begin
              for (int f = cur_idx + 1; f < 8; f++) if (pick < 0 && m_pend[f]) pick = f;
              if (pick < 0) begin
                for (int f = cur_idx - 1; f >= 0; f--) if (pick < 0 && m_pend[f]) pick = f;
                if (pick >= 0) m_up = 1'b0;
              end
            end else begin
              for (int f = cur_idx - 1; f >= 0; f--) if (pick < 0 && m_pend[f]) pick = f;
              if (pick < 0) begin
                for (int f = cur_idx + 1; f < 8; f++) if (pick < 0 && m_pend[f]) pick = f;
                if (pick >= 0) m_up = 1'b1;
              end
            end
          end
          if (pick >= 0) begin
            m_tgt = pick; m_phase = PhWait; m_free = 0; m_home = 0;
          end else begin
`ifdef ELC_HOME_RETURN_EN
            if (m_pend == 8'h00 && call_btn == 8'h00 && out_current_floor != 8'h01 && !m_ferr)
            begin
              m_home++;
              if (m_home == HOME) begin
                m_tgt = 0; m_phase = PhWait; m_free = 0; m_home = 0;
              end
            end else begin
              m_home = 0;
            end
`endif
          end
        end
        PhWait: begin
          m_home = 0;
          if (complete) begin
            clr = tgt_mask(m_tgt); m_tgt = -1; m_phase = PhDwell; m_dwell = DW;
          end else if (!door_alert && !weight_alert) begin
            m_free++;
            if (m_free == TO) begin m_stall = 1'b1; m_phase = PhStall; end
          end
        end
        PhStall: begin
          m_home = 0;
          if (complete) begin
            clr = tgt_mask(m_tgt); m_tgt = -1; m_stall = 1'b0;
            m_phase = PhDwell; m_dwell = DW;
          end
        end
        default: begin
          m_home = 0;
          m_dwell--;
          if (m_dwell == 0) m_phase = PhIdle;
        end
      endcase
      m_pend = (m_pend | call_btn) & ~clr;
      m_ferr = ($countones(out_current_floor) != 1);
    end
  end

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check8("request_floor", request_floor, tgt_mask(m_tgt));
      check8("req_valid", {7'd0, req_valid}, {7'd0, m_tgt >= 0});
      check8("pending", pending, m_pend);
      check8("scan_up", {7'd0, scan_up}, {7'd0, m_up});
      check8("stall_alert", {7'd0, stall_alert}, {7'd0, m_stall});
      check8("floor_err", {7'd0, floor_err}, {7'd0, m_ferr});
    end
  end

  initial begin
    // Reset with all buttons held.
    reset = 1'b1; call_btn = 8'hFF; out_current_floor = 8'h80;
    cyc(3);
    check8("rst_pending", pending, 8'h00);
    check8("rst_req_valid", {7'd0, req_valid}, 8'h00);
    check8("rst_scan_up", {7'd0, scan_up}, 8'h01);
    reset = 1'b0; call_btn = 8'h00;
    chk_en = 1'b1;

    // Press floor 0 from floor 7: latch, then issue with reversal.
    call_btn = 8'h01; cyc(1); call_btn = 8'h00;
    check8("lat_pending", pending, 8'h01);
    check8("lat_req_valid", {7'd0, req_valid}, 8'h00);
    cyc(1);
    check8("iss_request", request_floor, 8'h01);
    check8("iss_req_valid", {7'd0, req_valid}, 8'h01);
    check8("iss_scan_up", {7'd0, scan_up}, 8'h00);
    complete = 1'b1; cyc(1); complete = 1'b0; out_current_floor = 8'h01;
    check8("done_pending", pending, 8'h00);
    cyc(4);

    // SCAN from floor 2 going up with calls at 0, 5, 7.
    reset = 1'b1; out_current_floor = 8'h04; cyc(1); reset = 1'b0;
    call_btn = 8'hA1; cyc(1); call_btn = 8'h00; cyc(1);
    check8("scan_first", request_floor, 8'h20);
    cyc(3);
    complete = 1'b1; cyc(1); complete = 1'b0; out_current_floor = 8'h20;
    cyc(3);
    check8("scan_second", request_floor, 8'h80);
    complete = 1'b1; cyc(1); complete = 1'b0; out_current_floor = 8'h80;
    cyc(3);
    check8("scan_third", request_floor, 8'h01);
    check8("scan_third_dir", {7'd0, scan_up}, 8'h00);
    complete = 1'b1; cyc(1); complete = 1'b0; out_current_floor = 8'h01;
    check8("scan_empty", pending, 8'h00);
    cyc(3);

    // Alerts freeze the timeout; then stall after exactly TO free cycles.
    call_btn = 8'h08; cyc(1); call_btn = 8'h00; weight_alert = 1'b1; cyc(1);
    check8("stall_req", request_floor, 8'h08);
    cyc(200);
    check8("alert_no_stall", {7'd0, stall_alert}, 8'h00);
    weight_alert = 1'b0; door_alert = 1'b1; cyc(10); door_alert = 1'b0;
    cyc(TO - 1);
    check8("stall_early", {7'd0, stall_alert}, 8'h00);
    cyc(1);
    check8("stall_set", {7'd0, stall_alert}, 8'h01);
    complete = 1'b1; cyc(1); complete = 1'b0;
    check8("stall_clear", {7'd0, stall_alert}, 8'h00);
    check8("stall_pending", pending, 8'h00);
    cyc(3);

    // Complete on the timeout cycle, with a same-cycle press of the served floor.
    call_btn = 8'h08; cyc(1); call_btn = 8'h00; cyc(1);
    cyc(TO - 1);
    complete = 1'b1; call_btn = 8'h08; cyc(1); complete = 1'b0; call_btn = 8'h00;
    check8("prio_stall", {7'd0, stall_alert}, 8'h00);
    check8("prio_pending", pending, 8'h00);
    check8("prio_req_valid", {7'd0, req_valid}, 8'h00);
    cyc(3);

    // Reset in the middle of WAIT.
    call_btn = 8'h10; cyc(1); call_btn = 8'h00; cyc(1);
    call_btn = 8'h40; cyc(1); call_btn = 8'h00;
    reset = 1'b1; cyc(1); reset = 1'b0;
    check8("midrst_req_valid", {7'd0, req_valid}, 8'h00);
    check8("midrst_pending", pending, 8'h00);

    // Bad floor indication blocks selection.
    out_current_floor = 8'h00; cyc(1);
    check8("ferr_zero", {7'd0, floor_err}, 8'h01);
    call_btn = 8'h10; cyc(1); call_btn = 8'h00; cyc(3);
    check8("ferr_no_issue", {7'd0, req_valid}, 8'h00);
    check8("ferr_pending", pending, 8'h10);
    out_current_floor = 8'h05; cyc(2);
    check8("ferr_multi", {7'd0, floor_err}, 8'h01);
    check8("ferr_multi_noiss", {7'd0, req_valid}, 8'h00);
    out_current_floor = 8'h01; cyc(2);
    check8("ferr_recover", request_floor, 8'h10);
    check8("ferr_cleared", {7'd0, floor_err}, 8'h00);
    complete = 1'b1; cyc(1); complete = 1'b0; cyc(3);

    // Idle away from floor 0 with no calls.
    out_current_floor = 8'h40; cyc(40);
`ifdef ELC_HOME_RETURN_EN
    check8("home_request", request_floor, 8'h01);
`else
    check8("no_home_request", {7'd0, req_valid}, 8'h00);
`endif
    cyc(2);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
